stack_sequencer: RTL and testbench

STACK_SEQUENCER -- requirements
Module: stack_sequencer

---
 rtl/stack_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: hardware stack engine for CALL/INT/RET/RTI/PUSH/POP.
// The stack is made of 16-bit words and grows downward from SP_RESET.
// Optional feature: define STACK_OVF_DET_EN to drop operations that would
// overflow or underflow the stack and to raise the sticky stackErr flag.
// With the macro undefined, sp wraps modulo 2^32 and stackErr is tied low.
module stack_sequencer #(
    parameter logic [31:0] SP_RESET   = 32'h000FFFFF,
    parameter logic [31:0] INT_VECTOR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        intReq,
    input  logic        retReq,
    input  logic        callReq,
    input  logic        popReq,
    input  logic        pushReq,
    input  logic        rtiFlag,
    input  logic [31:0] pcIn,
    input  logic [31:0] callTarget,
    input  logic [15:0] pushData,
    input  logic [15:0] memRdata,
    output logic [31:0] memAddr,
    output logic [15:0] memWdata,
    output logic        memWE,
    output logic        memRE,
    output logic [31:0] pcOut,
    output logic        pcLoad,
    output logic [15:0] popData,
    output logic        popValid,
    output logic        ccrSave,
    output logic        ccrRestore,
    output logic        busy,
    output logic [31:0] sp,
    output logic        stackErr
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_HI,
        RD_LO,
        PUSH1,
        POP1
    } state_t;

    state_t      state;
    logic [31:0] sp_r;
    logic        is_int;
    logic        is_rti;
    logic [31:0] pc_lat;
    logic [31:0] tgt_lat;
    logic [15:0] ret_hi;
    logic [31:0] mem_addr_r;
    logic [15:0] mem_wdata_r;
    logic        mem_we_r;
    logic        mem_re_r;
    logic [31:0] pc_out_r;
    logic        pc_load_r;
    logic        pop_valid_r;
    logic        ccr_save_r;
    logic        ccr_restore_r;
    logic        stack_err_r;

    logic        push_ovf;
    logic        wr2_ovf;
    logic        pop_unf;
    logic        rd2_unf;

    // Stack-limit checks evaluated against the current stack pointer
    always_comb begin
        push_ovf = 1'b0;
        wr2_ovf  = 1'b0;
        pop_unf  = 1'b0;
        rd2_unf  = 1'b0;
`ifdef STACK_OVF_DET_EN
        push_ovf = (sp_r < 32'd1);
        wr2_ovf  = (sp_r < 32'd2);
        pop_unf  = (({1'b0, sp_r} + 33'd1) > {1'b0, SP_RESET});
        rd2_unf  = (({1'b0, sp_r} + 33'd2) > {1'b0, SP_RESET});
`endif
    end

    // Sequencer: accepts one request in IDLE and drives each memory access
    // from registers set on entry to the access state. sp moves on the same
    // edge, so during an access cycle sp already shows its post-access value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sp_r          <= SP_RESET;
            is_int        <= 1'b0;
            is_rti        <= 1'b0;
            pc_lat        <= '0;
            tgt_lat       <= '0;
            ret_hi        <= '0;
            mem_addr_r    <= SP_RESET;
            mem_wdata_r   <= '0;
            mem_we_r      <= 1'b0;
            mem_re_r      <= 1'b0;
            pc_out_r      <= '0;
            pc_load_r     <= 1'b0;
            pop_valid_r   <= 1'b0;
            ccr_save_r    <= 1'b0;
            ccr_restore_r <= 1'b0;
            stack_err_r   <= 1'b0;
        end else begin
            mem_addr_r    <= sp_r;
            mem_wdata_r   <= '0;
            mem_we_r      <= 1'b0;
            mem_re_r      <= 1'b0;
            pc_load_r     <= 1'b0;
            pop_valid_r   <= 1'b0;
            ccr_save_r    <= 1'b0;
            ccr_restore_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (intReq) begin
                        if (wr2_ovf) begin
                            stack_err_r <= 1'b1;
                        end else begin
                            is_int      <= 1'b1;
                            pc_lat      <= pcIn;
                            state       <= WR_LO;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= sp_r;
                            mem_wdata_r <= pcIn[15:0];
                            ccr_save_r  <= 1'b1;
                            sp_r        <= sp_r - 32'd1;
                        end
                    end else if (retReq) begin
                        if (rd2_unf) begin
                            stack_err_r <= 1'b1;
                        end else begin
                            is_rti     <= rtiFlag;
                            state      <= RD_HI;
                            mem_re_r   <= 1'b1;
                            mem_addr_r <= sp_r + 32'd1;
                            sp_r       <= sp_r + 32'd1;
                        end
                    end else if (callReq) begin
                        if (wr2_ovf) begin
                            stack_err_r <= 1'b1;
                        end else begin
                            is_int      <= 1'b0;
                            pc_lat      <= pcIn;
                            tgt_lat     <= callTarget;
                            state       <= WR_LO;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= sp_r;
                            mem_wdata_r <= pcIn[15:0];
                            sp_r        <= sp_r - 32'd1;
                        end
                    end else if (popReq) begin
                        if (pop_unf) begin
                            stack_err_r <= 1'b1;
                        end else begin
                            state       <= POP1;
                            mem_re_r    <= 1'b1;
                            mem_addr_r  <= sp_r + 32'd1;
                            pop_valid_r <= 1'b1;
                            sp_r        <= sp_r + 32'd1;
                        end
                    end else if (pushReq) begin
                        if (push_ovf) begin
                            stack_err_r <= 1'b1;
                        end else begin
                            state       <= PUSH1;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= sp_r;
                            mem_wdata_r <= pushData;
                            sp_r        <= sp_r - 32'd1;
                        end
                    end
                end
                WR_LO: begin
                    state       <= WR_HI;
                    mem_we_r    <= 1'b1;
                    mem_addr_r  <= sp_r;
                    mem_wdata_r <= pc_lat[31:16];
                    sp_r        <= sp_r - 32'd1;
                    pc_load_r   <= 1'b1;
                    pc_out_r    <= is_int ? INT_VECTOR : tgt_lat;
                end
                RD_HI: begin
                    ret_hi        <= memRdata;
                    state         <= RD_LO;
                    mem_re_r      <= 1'b1;
                    mem_addr_r    <= sp_r + 32'd1;
                    sp_r          <= sp_r + 32'd1;
                    pc_load_r     <= 1'b1;
                    ccr_restore_r <= is_rti;
                end
                RD_LO: begin
                    pc_out_r <= {ret_hi, memRdata};
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read data arrives combinationally during the read cycle, so the
    // returned PC low half and the popped word are passed straight through
    always_comb begin
        pcOut   = (state == RD_LO) ? {ret_hi, memRdata} : pc_out_r;
        popData = pop_valid_r ? memRdata : '0;
    end

    assign memAddr    = mem_addr_r;
    assign memWdata   = mem_wdata_r;
    assign memWE      = mem_we_r;
    assign memRE      = mem_re_r;
    assign pcLoad     = pc_load_r;
    assign popValid   = pop_valid_r;
    assign ccrSave    = ccr_save_r;
    assign ccrRestore = ccr_restore_r;
    assign busy       = (state != IDLE);
    assign sp         = sp_r;
    assign stackErr   = stack_err_r;

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized bench for stack_sequencer against a word-level stack model.
module tb_stack_sequencer;

    localparam logic [31:0] SP_RST = 32'h000FFFFF;
    localparam logic [31:0] INT_V  = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        intReq = 1'b0, retReq = 1'b0, callReq = 1'b0, popReq = 1'b0, pushReq = 1'b0;
    logic        rtiFlag = 1'b0;
    logic [31:0] pcIn = '0, callTarget = '0;
    logic [15:0] pushData = '0;
    logic [15:0] memRdata;
    logic [31:0] memAddr, pcOut, sp;
    logic [15:0] memWdata, popData;
    logic        memWE, memRE, pcLoad, popValid, ccrSave, ccrRestore, busy, stackErr;

    int checks = 0;
    int errors = 0;

    stack_sequencer #(.SP_RESET(SP_RST), .INT_VECTOR(INT_V)) dut (
        .clk(clk), .rst(rst),
        .intReq(intReq), .retReq(retReq), .callReq(callReq), .popReq(popReq), .pushReq(pushReq),
        .rtiFlag(rtiFlag), .pcIn(pcIn), .callTarget(callTarget), .pushData(pushData),
        .memRdata(memRdata), .memAddr(memAddr), .memWdata(memWdata), .memWE(memWE), .memRE(memRE),
        .pcOut(pcOut), .pcLoad(pcLoad), .popData(popData), .popValid(popValid),
        .ccrSave(ccrSave), .ccrRestore(ccrRestore), .busy(busy), .sp(sp), .stackErr(stackErr)
    );

    always #5 clk = ~clk;

    // Memory fixture: 256-word window, combinational read, write on clock
    logic [15:0] tmem [0:255] = '{default: 16'h0};
    assign memRdata = tmem[memAddr[7:0]];
    always @(posedge clk) if (memWE) tmem[memAddr[7:0]] <= memWdata;

    // Reference model: stack pointer, word depth and memory contents
    logic [31:0] mdl_sp;
    int          depth;
    logic [15:0] mdl_mem [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : 16'h0;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".we"}, 32'(memWE), 32'd0);
        check({tag, ".re"}, 32'(memRE), 32'd0);
        check({tag, ".addr"}, memAddr, mdl_sp);
        check({tag, ".wdata"}, 32'(memWdata), 32'd0);
        check({tag, ".pcload"}, 32'(pcLoad), 32'd0);
        check({tag, ".popvalid"}, 32'(popValid), 32'd0);
        check({tag, ".sp"}, sp, mdl_sp);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        mdl_sp = SP_RST;
        depth  = 0;
        check_idle(tag);
        check({tag, ".pcout"}, pcOut, 32'd0);
        check({tag, ".popdata"}, 32'(popData), 32'd0);
        check({tag, ".err"}, 32'(stackErr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // req bits: {int, ret, call, pop, push}
    task automatic run_op(input logic [4:0] req, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [15:0] d, input logic rti);
        int w;
        logic [31:0] s;
        logic [15:0] hi, lo;
        w = req[4] ? 0 : req[3] ? 1 : req[2] ? 2 : req[1] ? 3 : 4;
        @(negedge clk);
        {intReq, retReq, callReq, popReq, pushReq} = req;
        pcIn = pc; callTarget = tgt; pushData = d; rtiFlag = rti;
        @(negedge clk);
        {intReq, retReq, callReq, popReq, pushReq} = 5'b0;
        s = mdl_sp;
        case (w)
            0, 2: begin
                check("wr1.we", 32'(memWE), 32'd1);
                check("wr1.re", 32'(memRE), 32'd0);
                check("wr1.addr", memAddr, s);
                check("wr1.wdata", 32'(memWdata), 32'(pc[15:0]));
                check("wr1.ccrsave", 32'(ccrSave), 32'(w == 0));
                check("wr1.pcload", 32'(pcLoad), 32'd0);
                check("wr1.sp", sp, s - 32'd1);
                check("wr1.busy", 32'(busy), 32'd1);
                mdl_mem[s] = pc[15:0];
                {intReq, retReq, callReq, popReq, pushReq} = 5'($urandom);
                pcIn = $urandom; callTarget = $urandom; pushData = 16'($urandom);
                @(negedge clk);
                {intReq, retReq, callReq, popReq, pushReq} = 5'b0;
                check("wr2.we", 32'(memWE), 32'd1);
                check("wr2.addr", memAddr, s - 32'd1);
                check("wr2.wdata", 32'(memWdata), 32'(pc[31:16]));
                check("wr2.pcload", 32'(pcLoad), 32'd1);
                check("wr2.pcout", pcOut, (w == 0) ? INT_V : tgt);
                check("wr2.ccrsave", 32'(ccrSave), 32'd0);
                check("wr2.sp", sp, s - 32'd2);
                mdl_mem[s - 32'd1] = pc[31:16];
                mdl_sp = s - 32'd2;
                depth += 2;
            end
            1: begin
                hi = mdl_rd(s + 32'd1);
                lo = mdl_rd(s + 32'd2);
                check("rd1.re", 32'(memRE), 32'd1);
                check("rd1.we", 32'(memWE), 32'd0);
                check("rd1.addr", memAddr, s + 32'd1);
                check("rd1.pcload", 32'(pcLoad), 32'd0);
                check("rd1.sp", sp, s + 32'd1);
                {intReq, retReq, callReq, popReq, pushReq} = 5'($urandom);
                @(negedge clk);
                {intReq, retReq, callReq, popReq, pushReq} = 5'b0;
                check("rd2.re", 32'(memRE), 32'd1);
                check("rd2.addr", memAddr, s + 32'd2);
                check("rd2.pcload", 32'(pcLoad), 32'd1);
                check("rd2.pcout", pcOut, {hi, lo});
                check("rd2.ccrrestore", 32'(ccrRestore), 32'(rti));
                check("rd2.sp", sp, s + 32'd2);
                mdl_sp = s + 32'd2;
                depth -= 2;
            end
            3: begin
                check("pop.re", 32'(memRE), 32'd1);
                check("pop.we", 32'(memWE), 32'd0);
                check("pop.addr", memAddr, s + 32'd1);
                check("pop.valid", 32'(popValid), 32'd1);
                check("pop.data", 32'(popData), 32'(mdl_rd(s + 32'd1)));
                check("pop.sp", sp, s + 32'd1);
                mdl_sp = s + 32'd1;
                depth -= 1;
            end
            default: begin
                check("push.we", 32'(memWE), 32'd1);
                check("push.re", 32'(memRE), 32'd0);
                check("push.addr", memAddr, s);
                check("push.wdata", 32'(memWdata), 32'(d));
                check("push.sp", sp, s - 32'd1);
                mdl_mem[s] = d;
                mdl_sp = s - 32'd1;
                depth += 1;
            end
        endcase
        @(negedge clk);
        check_idle("done");
        check("done.ccr", 32'({ccrSave, ccrRestore}), 32'd0);
    endtask

    initial begin
        logic [4:0] m;
        mdl_sp = SP_RST;
        depth  = 0;
        #12;
        do_reset("reset");

        // Directed scenarios
        run_op(5'b00001, 32'h0, 32'h0, 16'hABCD, 1'b0);
        run_op(5'b00010, 32'h0, 32'h0, 16'h0, 1'b0);
        run_op(5'b00100, 32'h00012345, 32'h00000200, 16'h0, 1'b0);
        check("call.mem_lo", 32'(tmem[8'hFF]), 32'h2345);
        check("call.mem_hi", 32'(tmem[8'hFE]), 32'h0001);
        run_op(5'b01000, 32'h0, 32'h0, 16'h0, 1'b0);
        run_op(5'b10100, 32'h00000010, 32'h00000777, 16'h0, 1'b0);
        run_op(5'b01000, 32'h0, 32'h0, 16'h0, 1'b1);

        // Reset during the second write of a CALL
        @(negedge clk);
        callReq = 1'b1; pcIn = 32'h0000BEEF; callTarget = 32'h00000300;
        @(negedge clk);
        callReq = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        mdl_sp = SP_RST;
        depth  = 0;
        check_idle("midreset");
        check("midreset.pcout", pcOut, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // POP straight after reset
        do_reset("reset2");
        popReq = 1'b1;
        @(negedge clk);
        popReq = 1'b0;
`ifdef STACK_OVF_DET_EN
        check("underflow.re", 32'(memRE), 32'd0);
        check("underflow.sp", sp, SP_RST);
        check("underflow.err", 32'(stackErr), 32'd1);
        check("underflow.busy", 32'(busy), 32'd0);
`else
        check("wrap.re", 32'(memRE), 32'd1);
        check("wrap.addr", memAddr, 32'h00100000);
        check("wrap.sp", sp, 32'h00100000);
        check("wrap.valid", 32'(popValid), 32'd1);
`endif
        do_reset("reset3");

        // Random request mixes, kept inside the modelled stack window
        for (int i = 0; i < 300; i++) begin
            m = 5'($urandom);
            for (int k = 0; k < 5; k++) begin
                if (m[4]) begin
                    if (depth > 100) m[4] = 1'b0;
                end else if (m[3]) begin
                    if (depth < 2) m[3] = 1'b0;
                end else if (m[2]) begin
                    if (depth > 100) m[2] = 1'b0;
                end else if (m[1]) begin
                    if (depth < 1) m[1] = 1'b0;
                end else if (m[0]) begin
                    if (depth > 100) m[0] = 1'b0;
                end
            end
            if (m == 5'b0) m = (depth > 100) ? 5'b00010 : 5'b00001;
            run_op(m, $urandom, $urandom, 16'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
